// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with a two-entry skid buffer.
// Adds flush, $zero write suppression and a saturating stall counter.
module mem_wb_skid_reg #(
    parameter int XLEN         = 32,
    parameter int REG_W        = 5,
    parameter int CTRL_W       = 2,
    parameter int REGWRITE_BIT = 1,
    parameter bit DROP_X0      = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_wb_in,
    input  logic [XLEN-1:0]   read_data_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] mem_ctrl_wb,
    output logic [XLEN-1:0]   read_data,
    output logic [XLEN-1:0]   mem_alu_result,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rdata;
        logic [XLEN-1:0]   alu;
        logic [REG_W-1:0]  rd;
    } entry_t;

    state_t           state;
    state_t           state_nxt;
    entry_t           main_q;
    entry_t           main_d;
    entry_t           skid_q;
    entry_t           skid_d;
    entry_t           in_ent;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             in_fire;
    logic             out_fire;
    logic             stall;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stall     = out_valid & ~out_ready;

    // Incoming entry, with register-write stripped for x0 destinations
    always_comb begin
        in_ent.ctrl  = ctrl_wb_in;
        in_ent.rdata = read_data_in;
        in_ent.alu   = alu_result_in;
        in_ent.rd    = write_reg_in;
        if (DROP_X0 && write_reg_in == '0) begin
            in_ent.ctrl[REGWRITE_BIT] = 1'b0;
        end
    end

    // Next state and storage moves; flush empties but keeps head data
    always_comb begin
        state_nxt = state;
        main_d    = main_q;
        skid_d    = skid_q;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    main_d    = in_ent;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_nxt = FULL;
                    skid_d    = in_ent;
                end else if (in_fire && out_fire) begin
                    main_d    = in_ent;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = ONE;
                    main_d    = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            main_d    = main_q;
            skid_d    = skid_q;
        end
    end

    // Stall counter saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, storage and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mem_ctrl_wb    = out_valid ? main_q.ctrl : '0;
    assign read_data      = main_q.rdata;
    assign mem_alu_result = main_q.alu;
    assign mem_write_reg  = main_q.rd;
    assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg.
// Directed steps plus random traffic against a FIFO reference model.
module tb_mem_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ctrl_wb_in = '0;
    logic [31:0] read_data_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [4:0]  write_reg_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  mem_ctrl_wb;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic [3:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    int unsigned cnt;

    mem_wb_skid_reg #(
        .XLEN(32), .REG_W(5), .CTRL_W(2), .REGWRITE_BIT(1),
        .DROP_X0(1'b1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_wb_in(ctrl_wb_in), .read_data_in(read_data_in),
        .alu_result_in(alu_result_in), .write_reg_in(write_reg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_ctrl_wb(mem_ctrl_wb), .read_data(read_data),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic [1:0] c, logic [4:0] rd,
                         logic [31:0] alu, logic [31:0] rdata);
        in_valid      = v;
        ctrl_wb_in    = c;
        write_reg_in  = rd;
        alu_result_in = alu;
        read_data_in  = rdata;
    endtask

    // Reference: a queue of at most two entries, updated once per edge
    task automatic step();
        bit   has;
        bit   room;
        ent_t e;
        @(posedge clk);
        has  = (q.size() > 0);
        room = (q.size() < 2);
        if (!rst_n) begin
            q.delete();
            last = '{2'b0, 32'b0, 32'b0, 5'b0};
            cnt  = 0;
        end else begin
            if (has && !out_ready && cnt < 15) cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (has && out_ready) void'(q.pop_front());
                if (in_valid && room) begin
                    e.ctrl  = (write_reg_in == 0) ? (ctrl_wb_in & 2'b01)
                                                  : ctrl_wb_in;
                    e.rdata = read_data_in;
                    e.alu   = alu_result_in;
                    e.rd    = write_reg_in;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) last = q[0];
        end
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("ctrl", mem_ctrl_wb, (q.size() > 0) ? last.ctrl : 2'b0);
        chk("read_data", read_data, last.rdata);
        chk("alu", mem_alu_result, last.alu);
        chk("write_reg", mem_write_reg, last.rd);
        chk("stall_cnt", stall_cnt, cnt);
    endtask

    initial begin
        int unsigned saved;
        last = '{2'b0, 32'b0, 32'b0, 5'b0};
        cnt  = 0;
        @(negedge clk);

        // reset held two cycles with input offered
        rst_n = 1'b0;
        drive(1'b1, 2'b11, 5'd7, 32'h55, 32'h66);
        step();
        step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_alu", mem_alu_result, 32'h0);
        chk("rst_cnt", stall_cnt, 4'd0);
        rst_n = 1'b1;

        // streaming
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 5'd5, 32'h10, 32'hA0);
        step();
        chk("stream_A_alu", mem_alu_result, 32'h10);
        chk("stream_A_ctrl", mem_ctrl_wb, 2'b11);
        drive(1'b1, 2'b10, 5'd6, 32'h20, 32'hB0);
        step();
        chk("stream_B_alu", mem_alu_result, 32'h20);
        chk("stream_ready", in_ready, 1'b1);
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        step();
        chk("stream_drain", out_valid, 1'b0);
        chk("stream_hold", mem_alu_result, 32'h20);

        // back-pressure: A, B accepted, C held off
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 5'd1, 32'hA, 32'h1);
        step();
        drive(1'b1, 2'b11, 5'd2, 32'hB, 32'h2);
        step();
        chk("bp_full", in_ready, 1'b0);
        drive(1'b1, 2'b11, 5'd3, 32'hC, 32'h3);
        step();
        chk("bp_head_A", mem_alu_result, 32'hA);
        chk("bp_cnt", stall_cnt, 4'd2);
        out_ready = 1'b1;
        step();
        chk("bp_head_B", mem_alu_result, 32'hB);
        step();
        chk("bp_head_C", mem_alu_result, 32'hC);
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        step();
        chk("bp_empty", out_valid, 1'b0);

        // $zero write suppression
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 5'd0, 32'h77, 32'h0);
        step();
        chk("x0_drop", mem_ctrl_wb, 2'b01);
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 5'd3, 32'h78, 32'h0);
        step();
        chk("x3_keep", mem_ctrl_wb, 2'b11);

        // flush from FULL while input offered
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 5'd8, 32'h80, 32'h8);
        step();
        drive(1'b1, 2'b11, 5'd9, 32'h90, 32'h9);
        step();
        chk("fl_full", in_ready, 1'b0);
        saved = stall_cnt;
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ctrl", mem_ctrl_wb, 2'b00);
        chk("fl_ready", in_ready, 1'b1);
        chk("fl_cnt", stall_cnt, saved);

        // saturation after fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 5'd4, 32'h44, 32'h4);
        step();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", stall_cnt, 4'd15);
        step();
        chk("sat_hold", stall_cnt, 4'd15);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1) == 1, 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom);
            flush = out_ready && ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            step();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
